// File: rtl/request_dispatch.sv
// request_dispatch
//
// Accepts tagged messages from an inbound pipe and forwards each one as a
// single method call to one of NCHAN downstream channels. The tag selects
// the channel, where tag t picks channel t-1. A tag of 0, or one above
// NCHAN, is discarded and counted. One holding register sits between the
// pipe and the channels. When the selected channel is not ready, the held
// message blocks every channel, so delivery stays strictly in order.
//
// Ports
//   CLK                in   clock, rising edge
//   RST                in   synchronous active-high reset
//   pipe_enq__ENA      in   inbound message valid
//   pipe_enq_v         in   message: tag [31:0], then per channel meth/v
//   pipe_enq__RDY      out  block can take a message this cycle
//   request_enq__ENA   out  per-channel method enable (one-hot or zero)
//   request_enq_meth   out  held meth replicated on every channel slice
//   request_enq_v      out  held v replicated on every channel slice
//   request_enq__RDY   in   per-channel downstream ready
//   drop_count         out  saturating count of invalid-tag messages
//   busy               out  holding register occupied

module request_dispatch #(
  parameter  int NCHAN = 2,
  parameter  int ARGW  = 32,
  localparam int MSGW  = 32 + NCHAN*2*ARGW
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  pipe_enq__ENA,
  input  logic [MSGW-1:0]       pipe_enq_v,
  output logic                  pipe_enq__RDY,
  output logic [NCHAN-1:0]      request_enq__ENA,
  output logic [NCHAN*ARGW-1:0] request_enq_meth,
  output logic [NCHAN*ARGW-1:0] request_enq_v,
  input  logic [NCHAN-1:0]      request_enq__RDY,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam int KW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  // Holding register and drop counter
  logic            valid_r;
  logic [KW-1:0]   chan_r;
  logic [ARGW-1:0] meth_r;
  logic [ARGW-1:0] v_r;
  logic [15:0]     drop_r;

  // Decode of the inbound message
  logic [31:0]     tag_s;
  logic            tag_ok_s;
  logic [KW-1:0]   chan_in_s;
  logic [ARGW-1:0] meth_in_s;
  logic [ARGW-1:0] v_in_s;

  // Handshake terms
  logic            rdy_sel_s;
  logic            fire_s;
  logic            pipe_rdy_s;
  logic            accept_s;

  // Decode the tag and pull the addressed channel's meth/v slices.
  // The full 32-bit tag is compared, so stray upper bits make a tag invalid.
  always_comb begin
    tag_s     = pipe_enq_v[31:0];
    tag_ok_s  = (tag_s >= 32'd1) && (tag_s <= 32'(NCHAN));
    chan_in_s = '0;
    meth_in_s = '0;
    v_in_s    = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (tag_s == 32'(k + 1)) begin
        chan_in_s = KW'(k);
        meth_in_s = pipe_enq_v[32 + k*2*ARGW +: ARGW];
        v_in_s    = pipe_enq_v[32 + k*2*ARGW + ARGW +: ARGW];
      end else begin
        chan_in_s = chan_in_s;
      end
    end
  end

  // Pick the ready bit of the channel that owns the held message. A loop
  // is used here instead of a direct index so that a non-power-of-two
  // NCHAN never produces an out-of-range select.
  always_comb begin
    rdy_sel_s = 1'b0;
    for (int k = 0; k < NCHAN; k++) begin
      if (chan_r == KW'(k)) begin
        rdy_sel_s = request_enq__RDY[k];
      end else begin
        rdy_sel_s = rdy_sel_s;
      end
    end
  end

  // The pipe is ready when the register is empty, or when the register
  // drains this cycle. That allows one message per cycle. Readiness
  // deliberately ignores the inbound enable and data.
  always_comb begin
    fire_s     = valid_r & rdy_sel_s;
    pipe_rdy_s = ~RST & (~valid_r | fire_s);
    accept_s   = pipe_enq__ENA & pipe_rdy_s;
  end

  // Per-channel enables and replicated data slices
  genvar g;
  generate
    for (g = 0; g < NCHAN; g++) begin : g_chan
      assign request_enq__ENA[g]              = ~RST & valid_r & (chan_r == KW'(g))
                                                & request_enq__RDY[g];
      assign request_enq_meth[g*ARGW +: ARGW] = meth_r;
      assign request_enq_v[g*ARGW +: ARGW]    = v_r;
    end
  endgenerate

  assign pipe_enq__RDY = pipe_rdy_s;
  assign drop_count    = drop_r;
  assign busy          = valid_r;

  // Holding register load/drain and the saturating drop counter.
  // An invalid-tag accept never loads the register. If it coincides with
  // a fire, the register simply empties.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r <= 1'b0;
      chan_r  <= '0;
      meth_r  <= '0;
      v_r     <= '0;
      drop_r  <= 16'h0000;
    end else begin
      if (accept_s && tag_ok_s) begin
        valid_r <= 1'b1;
        chan_r  <= chan_in_s;
        meth_r  <= meth_in_s;
        v_r     <= v_in_s;
      end else if (fire_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (accept_s && !tag_ok_s && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end else begin
        drop_r <= drop_r;
      end
    end
  end

endmodule

// File: tb/tb_request_dispatch.sv
// Directed bench for request_dispatch. It uses a 2-channel/32-bit instance
// for the main scenarios and a 4-channel/16-bit instance for the slice
// mapping. Inputs change on the falling edge, and outputs are checked 1 ns
// later.

module tb_request_dispatch;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // 2-channel, 32-bit instance
  logic         d2_pena;
  logic [159:0] d2_msg;
  logic         d2_prdy;
  logic [1:0]   d2_rena;
  logic [63:0]  d2_meth;
  logic [63:0]  d2_v;
  logic [1:0]   d2_rrdy;
  logic [15:0]  d2_drop;
  logic         d2_busy;

  // 4-channel, 16-bit instance
  logic         d4_pena;
  logic [159:0] d4_msg;
  logic         d4_prdy;
  logic [3:0]   d4_rena;
  logic [63:0]  d4_meth;
  logic [63:0]  d4_v;
  logic [3:0]   d4_rrdy;
  logic [15:0]  d4_drop;
  logic         d4_busy;

  request_dispatch #(.NCHAN(2), .ARGW(32)) u_d2 (
    .CLK(CLK), .RST(RST),
    .pipe_enq__ENA(d2_pena), .pipe_enq_v(d2_msg), .pipe_enq__RDY(d2_prdy),
    .request_enq__ENA(d2_rena), .request_enq_meth(d2_meth), .request_enq_v(d2_v),
    .request_enq__RDY(d2_rrdy), .drop_count(d2_drop), .busy(d2_busy)
  );

  request_dispatch #(.NCHAN(4), .ARGW(16)) u_d4 (
    .CLK(CLK), .RST(RST),
    .pipe_enq__ENA(d4_pena), .pipe_enq_v(d4_msg), .pipe_enq__RDY(d4_prdy),
    .request_enq__ENA(d4_rena), .request_enq_meth(d4_meth), .request_enq_v(d4_v),
    .request_enq__RDY(d4_rrdy), .drop_count(d4_drop), .busy(d4_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] mk2(input logic [31:0] tag, input logic [31:0] m0,
                                       input logic [31:0] v0, input logic [31:0] m1,
                                       input logic [31:0] v1);
    return {v1, m1, v0, m0, tag};
  endfunction

  initial begin
    d2_pena = 1'b0; d2_msg = '0; d2_rrdy = 2'b11;
    d4_pena = 1'b0; d4_msg = '0; d4_rrdy = 4'b1111;

    // Reset: enable is ignored, outputs held low
    @(negedge CLK);
    d2_pena = 1'b1; d2_msg = mk2(32'd1, 32'h1, 32'h2, 32'h0, 32'h0);
    #1;
    chk("rst_prdy", d2_prdy, 0);
    chk("rst_ena", d2_rena, 0);
    @(negedge CLK);
    chk("rst_busy", d2_busy, 0);
    chk("rst_drop", d2_drop, 0);
    RST = 1'b0; d2_pena = 1'b0;
    #1;
    chk("post_rst_prdy", d2_prdy, 1);
    chk("post_rst_meth", d2_meth, 0);
    chk("post_rst_v", d2_v, 0);
    chk("post_rst_busy", d2_busy, 0);

    // Single message on channel 0
    @(negedge CLK);
    d2_pena = 1'b1; d2_msg = mk2(32'd1, 32'h11, 32'h22, 32'h0, 32'h0);
    #1 chk("single_prdy", d2_prdy, 1);
    @(negedge CLK);
    d2_pena = 1'b0;
    #1;
    chk("single_ena", d2_rena, 2'b01);
    chk("single_meth", d2_meth[31:0], 32'h11);
    chk("single_v", d2_v[31:0], 32'h22);
    chk("single_busy", d2_busy, 1);
    @(negedge CLK);
    #1;
    chk("single_idle_busy", d2_busy, 0);
    chk("single_idle_ena", d2_rena, 0);

    // Back-to-back stream of tags 2,1,2
    @(negedge CLK);
    d2_pena = 1'b1; d2_msg = mk2(32'd2, 32'h0, 32'h0, 32'hA1, 32'hB1);
    @(negedge CLK);
    d2_msg = mk2(32'd1, 32'hA2, 32'hB2, 32'h0, 32'h0);
    #1;
    chk("strm0_ena", d2_rena, 2'b10);
    chk("strm0_meth", d2_meth[63:32], 32'hA1);
    chk("strm0_prdy", d2_prdy, 1);
    @(negedge CLK);
    d2_msg = mk2(32'd2, 32'h0, 32'h0, 32'hA3, 32'hB3);
    #1;
    chk("strm1_ena", d2_rena, 2'b01);
    chk("strm1_meth", d2_meth[31:0], 32'hA2);
    chk("strm1_prdy", d2_prdy, 1);
    @(negedge CLK);
    d2_pena = 1'b0;
    #1;
    chk("strm2_ena", d2_rena, 2'b10);
    chk("strm2_v", d2_v[63:32], 32'hB3);
    @(negedge CLK);
    #1 chk("strm_idle_busy", d2_busy, 0);

    // Channel 1 stalled for 5 cycles while another message waits on the pipe
    @(negedge CLK);
    d2_pena = 1'b1; d2_msg = mk2(32'd2, 32'h0, 32'h0, 32'hC1, 32'hD1); d2_rrdy = 2'b01;
    @(negedge CLK);
    d2_msg = mk2(32'd1, 32'hEE, 32'hEF, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_prdy", d2_prdy, 0);
      chk("stall_ena", d2_rena, 0);
      chk("stall_meth", d2_meth, {32'hC1, 32'hC1});
      chk("stall_v", d2_v, {32'hD1, 32'hD1});
      @(negedge CLK);
    end
    d2_pena = 1'b0; d2_rrdy = 2'b11;
    #1;
    chk("stall_fire_ena", d2_rena, 2'b10);
    chk("stall_fire_prdy", d2_prdy, 1);
    @(negedge CLK);
    #1;
    chk("stall_after_ena", d2_rena, 0);
    chk("stall_after_busy", d2_busy, 0);

    // Invalid tags, and an invalid tag arriving while a message fires
    @(negedge CLK);
    d2_pena = 1'b1; d2_msg = mk2(32'd0, 32'h1, 32'h1, 32'h1, 32'h1);
    #1 chk("drop_prdy", d2_prdy, 1);
    @(negedge CLK);
    d2_msg = mk2(32'd3, 32'h1, 32'h1, 32'h1, 32'h1);
    #1 chk("drop_ena", d2_rena, 0);
    @(negedge CLK);
    d2_msg = mk2(32'd1, 32'h55, 32'h66, 32'h0, 32'h0);
    #1;
    chk("drop_cnt2", d2_drop, 16'd2);
    chk("drop_busy", d2_busy, 0);
    @(negedge CLK);
    d2_msg = mk2(32'h0001_0001, 32'h1, 32'h1, 32'h1, 32'h1);
    #1;
    chk("fire_drop_ena", d2_rena, 2'b01);
    chk("fire_drop_meth", d2_meth[31:0], 32'h55);
    @(negedge CLK);
    d2_pena = 1'b0;
    #1;
    chk("fire_drop_busy", d2_busy, 0);
    chk("fire_drop_cnt", d2_drop, 16'd3);
    chk("fire_drop_ena0", d2_rena, 0);

    // Saturation: preload the counter just below the top, then drop twice
    force u_d2.drop_r = 16'hFFFE;
    #1 release u_d2.drop_r;
    @(negedge CLK);
    d2_pena = 1'b1; d2_msg = mk2(32'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge CLK);
    d2_msg = mk2(32'd5, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 chk("sat_reach", d2_drop, 16'hFFFF);
    @(negedge CLK);
    d2_pena = 1'b0;
    #1;
    chk("sat_hold", d2_drop, 16'hFFFF);
    chk("sat_busy", d2_busy, 0);

    // Reset while a message is held on a stalled channel
    @(negedge CLK);
    d2_pena = 1'b1; d2_msg = mk2(32'd1, 32'h77, 32'h78, 32'h0, 32'h0); d2_rrdy = 2'b10;
    @(negedge CLK);
    d2_pena = 1'b0;
    #1;
    chk("mrst_held_busy", d2_busy, 1);
    chk("mrst_held_ena", d2_rena, 0);
    RST = 1'b1;
    #1;
    chk("mrst_ena", d2_rena, 0);
    chk("mrst_prdy", d2_prdy, 0);
    @(negedge CLK);
    RST = 1'b0; d2_rrdy = 2'b11;
    #1;
    chk("mrst_after_ena", d2_rena, 0);
    chk("mrst_after_busy", d2_busy, 0);
    chk("mrst_after_drop", d2_drop, 0);
    chk("mrst_after_prdy", d2_prdy, 1);
    chk("mrst_after_meth", d2_meth, 0);
    @(negedge CLK);
    #1 chk("mrst_later_ena", d2_rena, 0);

    // 4-channel instance: highest tag, distinct data per slice
    @(negedge CLK);
    d4_pena = 1'b1;
    d4_msg = {16'h2003, 16'h1003, 16'h2002, 16'h1002,
              16'h2001, 16'h1001, 16'h2000, 16'h1000, 32'd4};
    @(negedge CLK);
    d4_msg = {128'h0, 32'd5};
    #1;
    chk("c4_ena", d4_rena, 4'b1000);
    chk("c4_meth", d4_meth, {4{16'h1003}});
    chk("c4_v", d4_v, {4{16'h2003}});
    @(negedge CLK);
    d4_pena = 1'b0;
    #1;
    chk("c4_busy", d4_busy, 0);
    chk("c4_drop", d4_drop, 16'd1);
    chk("c4_ena0", d4_rena, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
